// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared types and constants for the RGMII receive decoder
package rgmii_pkg;
    typedef enum logic [1:0] {SPEED_10 = 2'd0, SPEED_100 = 2'd1, SPEED_1000 = 2'd2} rgmii_speed_t;
    typedef struct packed {
        logic       link;
        logic [1:0] speed;
        logic       duplex;
    } rgmii_status_t;
    typedef enum logic {IDLE = 1'b0, HIGH = 1'b1} rx_state_t;
    localparam int IDLE_STROBE_INTERVAL = 10;
    function automatic rgmii_status_t decode_status(input logic [3:0] rxd);
        return {rxd[0], rxd[2:1], rxd[3]};
    endfunction
endpackage

// File: rtl/rgmii_inband_status.sv
// rgmii_inband_status: qualifies idle in-band status samples and debounces them
module rgmii_inband_status import rgmii_pkg::*; #(
    parameter int STATUS_FILTER_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    rx_q1,
    input  logic [4:0]    rx_q2,
    output rgmii_status_t status
);
    localparam logic [7:0] THR = 8'(STATUS_FILTER_CYCLES);
    logic          busy, qual;
    logic [7:0]    cnt;
    rgmii_status_t cand, smp;
    assign busy = rx_q1[4] | rx_q2[4];
    assign qual = !busy && rx_q1[3:0] == rx_q2[3:0];
    assign smp  = decode_status(rx_q1[3:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            cand   <= '0;
            cnt    <= '0;
            status <= '0;
        end else begin
            if (busy || (qual && smp != cand)) begin
                cand <= smp;
                cnt  <= 8'd1;
            end else if (qual && cnt != 8'hff) begin
                cnt <= cnt + 8'd1;
            end
            if (cnt >= THR) status <= cand;
        end
    end
endmodule

// File: rtl/rgmii_rx_decode.sv
// rgmii_rx_decode: RGMII nibble pairs to GMII bytes at 10/100/1000M; in-band status under RGMII_RX_INBAND_STATUS_EN
module rgmii_rx_decode import rgmii_pkg::*; #(
    parameter int STATUS_FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rx_q1,
    input  logic [4:0] rx_q2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_valid,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
);
    logic       dv, er, gig, idle, tick, emit, nx_dv, nx_er, acc;
    logic [7:0] nx_rxd;
    logic [1:0] act_spd;
    logic [3:0] low, idle_cnt;
    rx_state_t  state, state_nx;
    assign dv   = rx_q1[4];
    assign er   = rx_q1[4] ^ rx_q2[4];
    assign gig  = act_spd[1];
    assign idle = state == IDLE && !dv;
    assign tick = !gig && idle && idle_cnt == 4'(IDLE_STROBE_INTERVAL - 1);
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb state_nx = (state == IDLE && dv && !gig) ? HIGH : IDLE;
    always_comb begin
        emit   = tick || state == HIGH;
        nx_rxd = (state == HIGH) ? {dv ? rx_q1[3:0] : 4'h0, low} : 8'h00;
        nx_dv  = state == HIGH;
        nx_er  = state == HIGH && (!dv || acc || er);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            act_spd       <= 2'(SPEED_1000);
            low           <= '0;
            acc           <= 1'b0;
            idle_cnt      <= '0;
            gmii_rxd      <= '0;
            gmii_rx_dv    <= 1'b0;
            gmii_rx_er    <= 1'b0;
            gmii_rx_valid <= 1'b0;
        end else begin
            if (idle) act_spd <= speed;
            if (state == IDLE && dv) begin
                low <= rx_q1[3:0];
                acc <= er;
            end
            idle_cnt <= (!gig && idle && !tick) ? idle_cnt + 4'd1 : 4'd0;
            if (gig) begin
                gmii_rxd      <= {rx_q2[3:0], rx_q1[3:0]};
                gmii_rx_dv    <= dv;
                gmii_rx_er    <= er;
                gmii_rx_valid <= 1'b1;
            end else begin
                gmii_rx_valid <= emit;
                if (emit) begin
                    gmii_rxd   <= nx_rxd;
                    gmii_rx_dv <= nx_dv;
                    gmii_rx_er <= nx_er;
                end
            end
        end
    end
    if (STATUS_FILTER_CYCLES < 1 || STATUS_FILTER_CYCLES > 255) begin : g_bad_cfg
        $error("STATUS_FILTER_CYCLES must be 1..255");
    end
`ifdef RGMII_RX_INBAND_STATUS_EN
    rgmii_status_t status;
    rgmii_inband_status #(.STATUS_FILTER_CYCLES(STATUS_FILTER_CYCLES)) u_status (
        .clk    (clk),
        .rst    (rst),
        .rx_q1  (rx_q1),
        .rx_q2  (rx_q2),
        .status (status)
    );
    assign link_up     = status.link;
    assign link_speed  = status.speed;
    assign link_duplex = status.duplex;
`else
    assign link_up     = 1'b0;
    assign link_speed  = 2'b00;
    assign link_duplex = 1'b0;
`endif
endmodule

// File: tb/tb_rgmii_rx_decode.sv
// tb_rgmii_rx_decode: randomized and directed check of rgmii_rx_decode against a frame-level model
module tb_rgmii_rx_decode;
    localparam int FILT = 4;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rx_q1, rx_q2;
    logic [1:0] speed;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv, gmii_rx_er, gmii_rx_valid, link_up, link_duplex;
    logic [1:0] link_speed;
    logic [10:0] gm;
    logic [3:0]  st;
    always #5 clk = ~clk;
    rgmii_rx_decode #(.STATUS_FILTER_CYCLES(FILT)) dut (
        .clk(clk), .rst(rst), .rx_q1(rx_q1), .rx_q2(rx_q2), .speed(speed),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .gmii_rx_valid(gmii_rx_valid), .link_up(link_up), .link_speed(link_speed),
        .link_duplex(link_duplex)
    );
    assign gm = {gmii_rx_valid, gmii_rxd, gmii_rx_dv, gmii_rx_er};
    assign st = {link_up, link_speed, link_duplex};

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       dv;
        logic       er;
        logic [3:0] st;
    } exp_t;
    exp_t e_nx, e_cur;
    int   total = 0, bad = 0;
    bit   chk = 0;

    // model state: active speed, pending nibbles, idle run, status as raw idle nibble
    logic [1:0] m_spd;
    logic [3:0] q_nib[$];
    logic       m_acc;
    int         idle_run, m_run;
    logic [3:0] m_cand, m_stat;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model();
        logic dv, er, in_frame;
        if (rst) begin
            m_spd = 2'd2; q_nib.delete(); idle_run = 0; m_acc = 0;
            m_cand = '0; m_run = 0; m_stat = '0; e_nx = '0;
            return;
        end
        dv = rx_q1[4];
        er = rx_q1[4] ^ rx_q2[4];
        in_frame = dv || q_nib.size() != 0;
        e_nx.v = 1'b0;
        if (m_spd >= 2) begin
            e_nx.v = 1'b1; e_nx.d = {rx_q2[3:0], rx_q1[3:0]}; e_nx.dv = dv; e_nx.er = er;
            idle_run = 0;
        end else if (q_nib.size() == 1) begin
            e_nx.v = 1'b1; e_nx.d = {dv ? rx_q1[3:0] : 4'h0, q_nib.pop_front()};
            e_nx.dv = 1'b1; e_nx.er = !dv || m_acc || er;
            idle_run = 0;
        end else if (dv) begin
            q_nib.push_back(rx_q1[3:0]); m_acc = er; idle_run = 0;
        end else begin
            idle_run++;
            if (idle_run == 10) begin
                e_nx.v = 1'b1; e_nx.d = 8'h00; e_nx.dv = 1'b0; e_nx.er = 1'b0; idle_run = 0;
            end
        end
        if (!in_frame) m_spd = speed;
`ifdef RGMII_RX_INBAND_STATUS_EN
        if (m_run >= FILT) m_stat = m_cand;
        if (rx_q1[4] || rx_q2[4] || (rx_q1[3:0] == rx_q2[3:0] && rx_q1[3:0] != m_cand)) begin
            m_cand = rx_q1[3:0]; m_run = 1;
        end else if (rx_q1[3:0] == rx_q2[3:0]) begin
            m_run = (m_run < 255) ? m_run + 1 : 255;
        end
        e_nx.st = {m_stat[0], m_stat[2:1], m_stat[3]};
`else
        e_nx.st = 4'h0;
`endif
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b);
        rx_q1 = a;
        rx_q2 = b;
        model();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pick();
        case ($urandom_range(0, 4))
            0: return 4'hD;
            1: return 4'hC;
            2: return 4'h5;
            3: return 4'h0;
            default: return 4'($urandom);
        endcase
    endfunction

    always @(posedge clk) e_cur <= e_nx;

    always @(negedge clk) if (chk) begin
        check("valid", 16'(gmii_rx_valid), 16'(e_cur.v));
        if (e_cur.v) check("byte", 16'({gmii_rxd, gmii_rx_dv, gmii_rx_er}), 16'({e_cur.d, e_cur.dv, e_cur.er}));
        check("status", 16'(st), 16'(e_cur.st));
    end

    initial begin
        logic [3:0] nib;
        int n;
        rst = 1'b1; rx_q1 = '0; rx_q2 = '0; speed = 2'd2;
        drive(5'h00, 5'h00);
        chk = 1;
        drive(5'h00, 5'h00);
        check("reset", 16'({gm, st}), 16'h0);
        rst = 1'b0;
        repeat (3) begin
            drive(5'h15, 5'h1A);
            check("gig_a5", 16'(gm), 16'({1'b1, 8'hA5, 1'b1, 1'b0}));
        end
        drive(5'h13, 5'h04);
        check("gig_er", 16'(gm), 16'({1'b1, 8'h43, 1'b1, 1'b1}));
        speed = 2'd1;
        drive(5'h00, 5'h00);
        check("gig_idle", 16'({gmii_rx_valid, gmii_rx_dv}), 16'b10);
        drive(5'h15, 5'h15);
        check("fe_gap", 16'(gmii_rx_valid), 16'h0);
        drive(5'h1D, 5'h1D);
        check("fe_d5", 16'(gm), 16'({1'b1, 8'hD5, 1'b1, 1'b0}));
        drive(5'h11, 5'h11);
        check("odd_gap1", 16'(gmii_rx_valid), 16'h0);
        drive(5'h12, 5'h12);
        check("odd_21", 16'(gm), 16'({1'b1, 8'h21, 1'b1, 1'b0}));
        drive(5'h13, 5'h13);
        check("odd_gap2", 16'(gmii_rx_valid), 16'h0);
        drive(5'h00, 5'h00);
        check("odd_03", 16'(gm), 16'({1'b1, 8'h03, 1'b1, 1'b1}));
        drive(5'h00, 5'h00);
        check("no_back2back", 16'(gmii_rx_valid), 16'h0);
        speed = 2'd2;
        drive(5'h00, 5'h00);
        drive(5'h15, 5'h1A);
        speed = 2'd1;
        drive(5'h15, 5'h1A);
        check("mid_switch", 16'(gm), 16'({1'b1, 8'hA5, 1'b1, 1'b0}));
        drive(5'h00, 5'h00);
        check("switch_idle", 16'({gmii_rx_valid, gmii_rx_dv}), 16'b10);
        drive(5'h17, 5'h17);
        drive(5'h18, 5'h18);
        check("after_switch", 16'(gm), 16'({1'b1, 8'h87, 1'b1, 1'b0}));
        drive(5'h19, 5'h19);
        rst = 1'b1;
        drive(5'h1A, 5'h1A);
        check("rst_mid", 16'({gm, st}), 16'h0);
        rst = 1'b0;
        drive(5'h00, 5'h00);
        rst = 1'b1;
        drive(5'h00, 5'h00);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive({1'b0, (i % 2) ? 4'hC : 4'hD}, {1'b0, (i % 2) ? 4'hC : 4'hD});
            check("alt_hold", 16'(st), 16'h0);
        end
        for (int i = 0; i < FILT; i++) begin
            drive(5'h0D, 5'h0D);
            check("stat_wait", 16'(st), 16'h0);
        end
        drive(5'h0D, 5'h0D);
`ifdef RGMII_RX_INBAND_STATUS_EN
        check("stat_d", 16'(st), 16'b1101);
`else
        check("stat_off", 16'(st), 16'h0);
`endif
        for (int f = 0; f < 160; f++) begin
            if ($urandom_range(0, 3) == 0) speed = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 14);
            nib = pick();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0) nib = pick();
                drive({1'b0, nib}, {1'b0, ($urandom_range(0, 7) == 0) ? 4'($urandom) : nib});
            end
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++)
                drive({1'b1, 4'($urandom)}, {$urandom_range(0, 15) != 0, 4'($urandom)});
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                drive(5'h00, 5'h00);
                rst = 1'b0;
            end
        end
        drive(5'h00, 5'h00);
        chk = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
